// File: rtl/postprocessing_stage_if.sv
// Handshake and data bundle for the modulo-adder post-processing stage.
// master drives the input beat and out_ready; slave is the stage itself.
interface postprocessing_stage_if #(parameter int W = 7);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_h;
  logic [W-1:0] in_a_prim;
  logic [W-1:0] in_c_plain;
  logic [W-1:0] in_c_corr;
  logic         in_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_corr;

  modport master (
    output in_valid, in_h, in_a_prim, in_c_plain, in_c_corr, in_cout, out_ready,
    input  in_ready, out_valid, out_sum, out_corr
  );

  modport slave (
    input  in_valid, in_h, in_a_prim, in_c_plain, in_c_corr, in_cout, out_ready,
    output in_ready, out_valid, out_sum, out_corr
  );
endinterface

// File: rtl/postprocessing_stage.sv
// Final modulo-adder stage: sum = cout ? a_prim^c_corr : h^c_plain, 2-cycle latency, 1 beat/cycle.
// Valid/ready both ends, in_ready combinational from out_ready; POSTPROC_STATS_EN adds corr_cnt.
module postprocessing_stage #(
  parameter int W     = 7,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  postprocessing_stage_if.slave bus,
  output logic [CNT_W-1:0] corr_cnt
);

  logic         s1_valid;
  logic [W-1:0] s1_h;
  logic [W-1:0] s1_a_prim;
  logic [W-1:0] s1_c_plain;
  logic [W-1:0] s1_c_corr;
  logic         s1_cout;

  logic         s2_valid;
  logic [W-1:0] s2_sum;
  logic         s2_corr;

  logic         s2_adv;
  logic         accept;

  assign s2_adv       = s1_valid & (~s2_valid | bus.out_ready);
  assign bus.in_ready = ~s1_valid | s2_adv;
  assign accept       = bus.in_valid & bus.in_ready;

  // Data registers load only on accept so idle (possibly X) inputs never enter the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_h       <= '0;
      s1_a_prim  <= '0;
      s1_c_plain <= '0;
      s1_c_corr  <= '0;
      s1_cout    <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid   <= 1'b1;
        s1_h       <= bus.in_h;
        s1_a_prim  <= bus.in_a_prim;
        s1_c_plain <= bus.in_c_plain;
        s1_c_corr  <= bus.in_c_corr;
        s1_cout    <= bus.in_cout;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_corr  <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid <= 1'b1;
        s2_sum   <= s1_cout ? (s1_a_prim ^ s1_c_corr) : (s1_h ^ s1_c_plain);
        s2_corr  <= s1_cout;
      end else if (bus.out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_sum   = s2_sum;
  assign bus.out_corr  = s2_corr;

`ifdef POSTPROC_STATS_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of corrected results actually taken downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (s2_valid & bus.out_ready & s2_corr & ~(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign corr_cnt = cnt_q;
`else
  assign corr_cnt = '0;
`endif

endmodule
